// File: rtl/regincr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regincr_pkg
//  Purpose  : Shared types and default configuration for the register-
//             incrementer accumulator stage (state enum, default widths).
//  Revision : 1.0 - initial release
// ============================================================================
package regincr_pkg;

  // Default configuration of the accumulator stage
  localparam int c_DTYPE     = 8;
  localparam int c_ACC_NBITS = 16;
  localparam int c_NSAMPLES  = 4;

  // Accumulator control states
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    SEND  = 1'b1
  } state_t;

endpackage : regincr_pkg
`default_nettype wire

// File: rtl/regincr_sat_add.sv
`default_nettype none
// ============================================================================
//  Module   : regincr_sat_add
//  Purpose  : Combinational WIDTH-bit adder with carry-out. When the macro
//             REGINCR_ACCUM_SAT_EN is defined the sum clamps to all-ones on
//             carry; otherwise it wraps modulo 2^WIDTH.
//  Revision : 1.0 - initial release
// ============================================================================
module regincr_sat_add #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  // Full-precision sum; the extra top bit is the carry out of WIDTH bits
  logic [WIDTH:0] w_full;

  assign w_full  = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o = w_full[WIDTH];

`ifdef REGINCR_ACCUM_SAT_EN
  // Clamp to the largest representable value when the sum no longer fits
  assign sum_o = w_full[WIDTH] ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
`else
  // Plain modulo-2^WIDTH wrap
  assign sum_o = w_full[WIDTH-1:0];
`endif

endmodule : regincr_sat_add
`default_nettype wire

// File: rtl/regincr_accum.sv
`default_nettype none
// ============================================================================
//  Module   : regincr_accum
//  Purpose  : Sums NSAMPLES consecutive DTYPE-bit samples (val/rdy input)
//             into an ACC_NBITS accumulator and presents each completed sum
//             with an overflow flag on a val/rdy output port.
//             Optional macro REGINCR_ACCUM_SAT_EN selects saturating
//             accumulation; default build wraps.
//  Revision : 1.0 - initial release
// ============================================================================
module regincr_accum
  import regincr_pkg::*;
#(
  parameter int DTYPE     = c_DTYPE,
  parameter int ACC_NBITS = c_ACC_NBITS,
  parameter int NSAMPLES  = c_NSAMPLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DTYPE-1:0]     in_msg,
  input  logic                 in_val,
  output logic                 in_rdy,
  output logic [ACC_NBITS-1:0] out_msg,
  output logic                 out_ovf,
  output logic                 out_val,
  input  logic                 out_rdy
);

  // Count value held when the final sample of a frame is being accepted
  localparam logic [7:0] c_LAST = 8'(NSAMPLES - 1);

  state_t               state_q, state_d;
  logic [ACC_NBITS-1:0] acc_q,   acc_d;
  logic [7:0]           cnt_q,   cnt_d;
  logic                 ovf_q,   ovf_d;

  logic [ACC_NBITS-1:0] w_in_ext;
  logic [ACC_NBITS-1:0] w_add_sum;
  logic                 w_add_carry;
  logic                 w_in_rdy;
  logic                 w_out_val;

  assign w_in_ext = ACC_NBITS'(in_msg);

  regincr_sat_add #(
    .WIDTH (ACC_NBITS)
  ) u_add (
    .a_i     (acc_q),
    .b_i     (w_in_ext),
    .sum_o   (w_add_sum),
    .carry_o (w_add_carry)
  );

  // State, accumulator, counter and overflow flag; cleared immediately on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and handshake decode; SEND may accept the first sample of the next frame
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    w_in_rdy  = 1'b0;
    w_out_val = 1'b0;
    case (state_q)
      ACCUM: begin
        w_in_rdy = 1'b1;
        if (in_val) begin
          acc_d = w_add_sum;
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | w_add_carry;
          if (cnt_q == c_LAST) begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        w_out_val = 1'b1;
        w_in_rdy  = out_rdy;
        if (out_rdy) begin
          if (in_val) begin
            // Same-cycle restart keeps one result per NSAMPLES cycles
            acc_d   = w_in_ext;
            ovf_d   = 1'b0;
            cnt_d   = 8'd1;
            state_d = (NSAMPLES == 1) ? SEND : ACCUM;
          end else begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = 8'd0;
            state_d = ACCUM;
          end
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // in_rdy must drop as soon as reset is asserted, even though state already reads ACCUM
  assign in_rdy  = reset & w_in_rdy;
  assign out_val = w_out_val;
  assign out_msg = acc_q;
  assign out_ovf = ovf_q;

endmodule : regincr_accum
`default_nettype wire

// File: tb/tb_regincr_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regincr_accum
//  Purpose  : Directed self-checking bench for regincr_accum: default
//             configuration, a narrow 9-bit accumulator and NSAMPLES=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regincr_accum;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  // Default configuration instance
  logic [7:0]  a_in_msg = '0;
  logic        a_in_val = 1'b0;
  logic        a_in_rdy;
  logic [15:0] a_out_msg;
  logic        a_out_ovf;
  logic        a_out_val;
  logic        a_out_rdy = 1'b1;

  // ACC_NBITS=9 instance
  logic [7:0]  b_in_msg = '0;
  logic        b_in_val = 1'b0;
  logic        b_in_rdy;
  logic [8:0]  b_out_msg;
  logic        b_out_ovf;
  logic        b_out_val;
  logic        b_out_rdy = 1'b1;

  // NSAMPLES=1 instance
  logic [7:0]  c_in_msg = '0;
  logic        c_in_val = 1'b0;
  logic        c_in_rdy;
  logic [15:0] c_out_msg;
  logic        c_out_ovf;
  logic        c_out_val;
  logic        c_out_rdy = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regincr_accum u_dut_a (
    .clk(clk), .reset(reset),
    .in_msg(a_in_msg), .in_val(a_in_val), .in_rdy(a_in_rdy),
    .out_msg(a_out_msg), .out_ovf(a_out_ovf), .out_val(a_out_val), .out_rdy(a_out_rdy)
  );

  regincr_accum #(.DTYPE(8), .ACC_NBITS(9), .NSAMPLES(4)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_msg(b_in_msg), .in_val(b_in_val), .in_rdy(b_in_rdy),
    .out_msg(b_out_msg), .out_ovf(b_out_ovf), .out_val(b_out_val), .out_rdy(b_out_rdy)
  );

  regincr_accum #(.DTYPE(8), .ACC_NBITS(16), .NSAMPLES(1)) u_dut_c (
    .clk(clk), .reset(reset),
    .in_msg(c_in_msg), .in_val(c_in_val), .in_rdy(c_in_rdy),
    .out_msg(c_out_msg), .out_ovf(c_out_ovf), .out_val(c_out_val), .out_rdy(c_out_rdy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and step just past the edge before touching anything
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- Reset ----------------
    reset    = 1'b0;
    a_in_val = 1'b1;
    a_in_msg = 8'd3;
    repeat (3) tick();
    check_val("rst_in_rdy",  32'(a_in_rdy),  32'd0);
    check_val("rst_out_val", 32'(a_out_val), 32'd0);
    check_val("rst_out_msg", 32'(a_out_msg), 32'd0);
    check_val("rst_out_ovf", 32'(a_out_ovf), 32'd0);
    check_val("rst_c_in_rdy", 32'(c_in_rdy), 32'd0);
    a_in_val = 1'b0;
    reset    = 1'b1;
    #1;
    check_val("rel_in_rdy", 32'(a_in_rdy), 32'd1);

    // ---------------- Basic 1,2,3,4 ----------------
    for (int i = 1; i <= 4; i++) begin
      a_in_msg = 8'(i);
      a_in_val = 1'b1;
      tick();
      if (i == 3) check_val("basic_val_early", 32'(a_out_val), 32'd0);
    end
    a_in_val = 1'b0;
    #1;
    check_val("basic_val", 32'(a_out_val), 32'd1);
    check_val("basic_msg", 32'(a_out_msg), 32'd10);
    check_val("basic_ovf", 32'(a_out_ovf), 32'd0);

    // ---------------- Backpressure ----------------
    a_out_rdy = 1'b0;
    a_in_val  = 1'b1;
    a_in_msg  = 8'd7;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("bp_msg",    32'(a_out_msg), 32'd10);
      check_val("bp_in_rdy", 32'(a_in_rdy),  32'd0);
      tick();
    end
    check_val("bp_val_held", 32'(a_out_val), 32'd1);
    a_out_rdy = 1'b1;
    #1;
    check_val("bp_release_in_rdy", 32'(a_in_rdy), 32'd1);
    tick();
    check_val("bp_restart_val", 32'(a_out_val), 32'd0);
    for (int i = 0; i < 3; i++) begin
      a_in_msg = 8'd1;
      tick();
    end
    a_in_val = 1'b0;
    #1;
    check_val("bp_frame2_val", 32'(a_out_val), 32'd1);
    check_val("bp_frame2_msg", 32'(a_out_msg), 32'd10);
    tick();
    check_val("bp_drain_val", 32'(a_out_val), 32'd0);
    check_val("bp_drain_msg", 32'(a_out_msg), 32'd0);

    // ---------------- Overflow on 9-bit accumulator ----------------
    b_in_msg = 8'hFF;
    b_in_val = 1'b1;
    repeat (4) tick();
    b_in_val = 1'b0;
    #1;
    check_val("ovf_val", 32'(b_out_val), 32'd1);
`ifdef REGINCR_ACCUM_SAT_EN
    check_val("ovf_msg", 32'(b_out_msg), 32'd511);
`else
    check_val("ovf_msg", 32'(b_out_msg), 32'd508);
`endif
    check_val("ovf_flag", 32'(b_out_ovf), 32'd1);
    tick();
    check_val("ovf_drain_flag", 32'(b_out_ovf), 32'd0);

    // ---------------- Reset mid-frame ----------------
    a_in_msg = 8'd9;
    a_in_val = 1'b1;
    repeat (2) tick();
    a_in_val = 1'b0;
    check_val("mid_partial", 32'(a_out_msg), 32'd18);
    reset = 1'b0;
    #1;
    check_val("mid_async_msg", 32'(a_out_msg), 32'd0);
    check_val("mid_in_rdy",    32'(a_in_rdy),  32'd0);
    tick();
    reset    = 1'b1;
    a_in_msg = 8'd1;
    a_in_val = 1'b1;
    repeat (4) tick();
    a_in_val = 1'b0;
    #1;
    check_val("mid_val", 32'(a_out_val), 32'd1);
    check_val("mid_msg", 32'(a_out_msg), 32'd4);
    check_val("mid_ovf", 32'(a_out_ovf), 32'd0);
    tick();

    // ---------------- NSAMPLES=1 streaming ----------------
    c_in_val = 1'b1;
    c_in_msg = 8'd5;
    tick();
    check_val("n1_val0", 32'(c_out_val), 32'd1);
    check_val("n1_msg0", 32'(c_out_msg), 32'd5);
    check_val("n1_in_rdy", 32'(c_in_rdy), 32'd1);
    c_in_msg = 8'd6;
    tick();
    check_val("n1_val1", 32'(c_out_val), 32'd1);
    check_val("n1_msg1", 32'(c_out_msg), 32'd6);
    c_in_msg = 8'd7;
    tick();
    check_val("n1_val2", 32'(c_out_val), 32'd1);
    check_val("n1_msg2", 32'(c_out_msg), 32'd7);
    c_in_val = 1'b0;
    tick();
    check_val("n1_idle", 32'(c_out_val), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_regincr_accum
`default_nettype wire
